ic_irq_responder: RTL and testbench

- Processor-side end of the interrupt-controller link.
- Samples the controller's global request `irq_out` and `irq_id`, and models a service routine of programmable length.
- Returns a single-cycle `ack` and drives `busy` while servicing.
- Used as a synthesizable CPU stand-in in chip-level simulation, and as the reference responder for controller verification.

---
 rtl/ic_pkg.sv | 11 +
 rtl/ic_svc_timer.sv | 29 ++
 rtl/ic_irq_responder.sv | 169 ++++++++++++++++
 tb/tb_ic_irq_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared types and constants for the interrupt-controller link.
package ic_pkg;
  localparam int IC_NUM_IRQ = 8;
  localparam int IC_ID_W    = 3;
  typedef enum logic [1:0] {
    IDLE,
    SERVICE,
    ACK,
    RELEASE
  } ic_resp_state_e;
endpackage

// File: rtl/ic_svc_timer.sv
// Loadable down-counter; done flags the last counted cycle.
module ic_svc_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));
endmodule

// File: rtl/ic_irq_responder.sv
// Processor-side interrupt responder with programmable service length.
// Optional ack/spurious statistics when IC_RESP_STATS_EN is defined.
module ic_irq_responder
  import ic_pkg::*;
#(
  parameter int NUM_IRQ      = IC_NUM_IRQ,
  parameter int ID_W         = IC_ID_W,
  parameter int LEN_W        = 8,
  parameter int GUARD_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             irq_out,
  input  logic [ID_W-1:0]  irq_id,
  input  logic             cpu_ie,
  input  logic [LEN_W-1:0] svc_len,
  output logic             ack,
  output logic             busy,
  output logic [ID_W-1:0]  active_id,
  output logic             spurious,
  input  logic [ID_W-1:0]  stat_sel,
  output logic [CNT_W-1:0] stat_count,
  output logic [CNT_W-1:0] stat_spur
);
  localparam int G_W = $clog2(GUARD_CYCLES + 1);

  ic_resp_state_e state_d, state_q;
  logic ack_d, ack_q;
  logic busy_d, busy_q;
  logic spur_d, spur_q;
  logic [ID_W-1:0] id_d, id_q;
  logic svc_load, svc_en, svc_done;
  logic grd_load, grd_en, grd_done;
  logic ack_evt, spur_evt;
  logic [LEN_W-1:0] svc_ld;

  assign svc_ld = (svc_len == '0) ? LEN_W'(1) : svc_len;

  ic_svc_timer #(.W(LEN_W)) u_svc (
    .clk      (clk),
    .rstn     (rstn),
    .load     (svc_load),
    .en       (svc_en),
    .load_val (svc_ld),
    .done     (svc_done)
  );

  ic_svc_timer #(.W(G_W)) u_grd (
    .clk      (clk),
    .rstn     (rstn),
    .load     (grd_load),
    .en       (grd_en),
    .load_val (G_W'(GUARD_CYCLES)),
    .done     (grd_done)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    spur_d   = 1'b0;
    id_d     = id_q;
    svc_load = 1'b0;
    svc_en   = 1'b0;
    grd_load = 1'b0;
    grd_en   = 1'b0;
    ack_evt  = 1'b0;
    spur_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (irq_out && cpu_ie) begin
          state_d  = SERVICE;
          id_d     = irq_id;
          busy_d   = 1'b1;
          svc_load = 1'b1;
        end
      end
      SERVICE: begin
        svc_en = 1'b1;
        busy_d = 1'b1;
        // withdrawal wins over completion on the final count
        if (!irq_out) begin
          state_d  = RELEASE;
          spur_d   = 1'b1;
          spur_evt = 1'b1;
          busy_d   = 1'b0;
          grd_load = 1'b1;
        end else if (svc_done) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      ACK: begin
        state_d  = RELEASE;
        busy_d   = 1'b0;
        ack_evt  = 1'b1;
        grd_load = 1'b1;
      end
      RELEASE: begin
        busy_d = 1'b0;
        grd_en = 1'b1;
        if (grd_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      spur_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      spur_q  <= spur_d;
      id_q    <= id_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign spurious  = spur_q;
  assign active_id = id_q;

`ifdef IC_RESP_STATS_EN
  logic [CNT_W-1:0] acks_d [NUM_IRQ];
  logic [CNT_W-1:0] acks_q [NUM_IRQ];
  logic [CNT_W-1:0] spc_d, spc_q;
  logic [CNT_W-1:0] stat_d, stat_q;

  // counts land as the ack cycle ends, so a reset inside it records nothing
  always_comb begin
    acks_d = acks_q;
    spc_d  = spc_q;
    stat_d = acks_q[stat_sel];
    if (ack_evt && acks_q[id_q] != '1)
      acks_d[id_q] = acks_q[id_q] + 1'b1;
    if (spur_evt && spc_q != '1)
      spc_d = spc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_IRQ; i++) acks_q[i] <= '0;
      spc_q  <= '0;
      stat_q <= '0;
    end else begin
      acks_q <= acks_d;
      spc_q  <= spc_d;
      stat_q <= stat_d;
    end
  end

  assign stat_count = stat_q;
  assign stat_spur  = spc_q;
`else
  localparam int unused_num = NUM_IRQ;
  logic unused_stat;
  assign unused_stat = ^{stat_sel, ack_evt, spur_evt};
  assign stat_count  = '0;
  assign stat_spur   = '0;
`endif
endmodule

// File: tb/tb_ic_irq_responder.sv
// Directed scoreboard bench for ic_irq_responder.
module tb_ic_irq_responder;
`ifdef IC_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       irq_out;
  logic [2:0] irq_id;
  logic       cpu_ie;
  logic [7:0] svc_len;
  logic       ack;
  logic       busy;
  logic [2:0] active_id;
  logic       spurious;
  logic [2:0] stat_sel;
  logic [7:0] stat_count;
  logic [7:0] stat_spur;

  int   checks = 0;
  int   errs = 0;
  int   cyc = 0;
  int   e0;
  int   nb;
  exp_t sbq[$];
  int   spq[$];

  ic_irq_responder #(
    .NUM_IRQ(8), .ID_W(3), .LEN_W(8),
    .GUARD_CYCLES(1), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_out    (irq_out),
    .irq_id     (irq_id),
    .cpu_ie     (cpu_ie),
    .svc_len    (svc_len),
    .ack        (ack),
    .busy       (busy),
    .active_id  (active_id),
    .spurious   (spurious),
    .stat_sel   (stat_sel),
    .stat_count (stat_count),
    .stat_spur  (stat_spur)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // scoreboard: pop an expectation for every ack / spurious pulse
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("ack_spur_excl", {31'd0, ack & spurious}, 0);
      if (ack) begin
        chk("ack_expected", {31'd0, sbq.size() != 0}, 1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_id", {29'd0, active_id}, e.id);
          chk("ack_busy", {31'd0, busy}, 1);
        end
      end
      if (spurious) begin
        chk("spur_expected", {31'd0, spq.size() != 0}, 1);
        if (spq.size() != 0) chk("spur_cycle", cyc, spq.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_acks(input int bound);
    for (int i = 0; i < bound && sbq.size() != 0; i++) step();
    chk("ack_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    rstn = 1'b0; irq_out = 1'b0; irq_id = '0; cpu_ie = 1'b0;
    svc_len = '0; stat_sel = '0;
    repeat (3) step();
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_spur", {31'd0, spurious}, 0);
    chk("rst_id", {29'd0, active_id}, 0);
    chk("rst_stat", {24'd0, stat_count}, 0);
    chk("rst_sspur", {24'd0, stat_spur}, 0);
    rstn = 1'b1;
    repeat (2) step();

    // basic service, length 4, id 5
    svc_len = 8'd4; cpu_ie = 1'b1; irq_id = 3'd5; irq_out = 1'b1;
    e0 = cyc + 1;
    sbq.push_back('{id: 5, cyc: e0 + 4});
    step();
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_id", {29'd0, active_id}, 5);
    chk("t1_noack", {31'd0, ack}, 0);
    wait_acks(20);
    irq_out = 1'b0; stat_sel = 3'd5;
    step();
    chk("t1_busy_off", {31'd0, busy}, 0);
    repeat (3) step();
    chk("t1_stat5", {24'd0, stat_count}, STATS ? 1 : 0);

    // zero length treated as one
    svc_len = 8'd0; irq_id = 3'd2; irq_out = 1'b1;
    e0 = cyc + 1; nb = 0;
    sbq.push_back('{id: 2, cyc: e0 + 1});
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy) nb++;
      if (sbq.size() == 0) irq_out = 1'b0;
    end
    chk("t2_busy_len", nb, 2);
    chk("t2_acked", sbq.size(), 0);
    sbq.delete();
    irq_out = 1'b0; stat_sel = 3'd2;
    repeat (3) step();
    chk("t2_stat2", {24'd0, stat_count}, STATS ? 1 : 0);

    // withdrawal mid-service
    svc_len = 8'd6; irq_id = 3'd3; irq_out = 1'b1;
    e0 = cyc + 1;
    repeat (3) step();
    irq_out = 1'b0;
    spq.push_back(e0 + 3);
    repeat (5) step();
    chk("t3_spur_seen", spq.size(), 0);
    spq.delete();
    chk("t3_busy", {31'd0, busy}, 0);
    chk("t3_sspur", {24'd0, stat_spur}, STATS ? 1 : 0);

    // gating by cpu_ie, then id stability and cpu_ie drop mid-service
    cpu_ie = 1'b0; irq_id = 3'd7; irq_out = 1'b1; svc_len = 8'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_gate_busy", {31'd0, busy}, 0);
    end
    cpu_ie = 1'b1;
    e0 = cyc + 1;
    sbq.push_back('{id: 7, cyc: e0 + 5});
    step();
    chk("t4_accept", {31'd0, busy}, 1);
    irq_id = 3'd1; cpu_ie = 1'b0;
    step();
    chk("t4_id_hold", {29'd0, active_id}, 7);
    wait_acks(20);
    irq_out = 1'b0; cpu_ie = 1'b1;
    repeat (4) step();

    // back-to-back on id 0, period L+GUARD+2 = 6
    svc_len = 8'd3; irq_id = 3'd0; irq_out = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 300; k++)
      sbq.push_back('{id: 0, cyc: e0 + 3 + 6 * k});
    wait_acks(300 * 6 + 20);
    irq_out = 1'b0; stat_sel = 3'd0;
    repeat (4) step();
    chk("t5_sat", {24'd0, stat_count}, STATS ? 255 : 0);
    chk("t5_idle", {31'd0, busy}, 0);

    // reset during the ack cycle
    svc_len = 8'd2; irq_id = 3'd4; irq_out = 1'b1;
    e0 = cyc + 1;
    sbq.push_back('{id: 4, cyc: e0 + 2});
    wait_acks(20);
    rstn = 1'b0;
    #1;
    chk("t6_ack_async", {31'd0, ack}, 0);
    chk("t6_busy_async", {31'd0, busy}, 0);
    irq_out = 1'b0; stat_sel = 3'd4;
    step();
    rstn = 1'b1;
    repeat (3) step();
    chk("t6_ack", {31'd0, ack}, 0);
    chk("t6_spur", {31'd0, spurious}, 0);
    chk("t6_id", {29'd0, active_id}, 0);
    chk("t6_stat4", {24'd0, stat_count}, 0);
    chk("t6_sspur", {24'd0, stat_spur}, 0);

    chk("end_sbq", sbq.size(), 0);
    chk("end_spq", spq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
